// File: rtl/dut_pkg.sv
// Shared constants, byte type and FSM state encoding for the program-3
// signed-multiply engine.
package dut_pkg;

  localparam int NUM_PAIRS    = 16;
  localparam int OPERAND_BASE = 0;
  localparam int RESULT_BASE  = 64;
  localparam int MEM_DEPTH    = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/data_mem.sv
// 256 x 8 byte memory: combinational read and synchronous write on one
// shared address. The array is not reset.
module data_mem
  import dut_pkg::*;
(
  input  logic       clk,
  input  logic       i_we,
  input  logic [7:0] i_addr,
  input  byte_t      i_wdata,
  output byte_t      o_rdata
);

  byte_t core [MEM_DEPTH];

  assign o_rdata = core[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) core[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/dut.sv
// Program-3 engine: reads 16 operand pairs from its data memory, writes
// the signed 32-bit products back big-endian, then raises done.
module dut
  import dut_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  state_t            r_state;
  logic [3:0]        r_k;
  logic [1:0]        r_bc;
  byte_t             r_a_hi;
  byte_t             r_a_lo;
  byte_t             r_b_hi;
  byte_t             r_b_lo;

  logic signed [15:0] w_a;
  logic signed [15:0] w_b;
  logic signed [31:0] w_a_ext;
  logic signed [31:0] w_b_ext;
  logic signed [31:0] w_prod;
  logic [7:0]         w_addr;
  logic               w_we;
  byte_t              w_wdata;
  byte_t              w_rdata;

  assign w_a     = $signed({r_a_hi, r_a_lo});
  assign w_b     = $signed({r_b_hi, r_b_lo});
  assign w_a_ext = 32'(w_a);
  assign w_b_ext = 32'(w_b);
  assign w_prod  = w_b_ext * w_a_ext;

  // Same byte index {k, bc} addresses operands in LOAD and results in STORE.
  always_comb begin
    w_addr = 8'(OPERAND_BASE) + {2'b00, r_k, r_bc};
    if (r_state == STORE) w_addr = 8'(RESULT_BASE) + {2'b00, r_k, r_bc};
  end

  always_comb begin
    w_wdata = '0;
    unique case (r_bc)
      2'd0: w_wdata = w_prod[31:24];
      2'd1: w_wdata = w_prod[23:16];
      2'd2: w_wdata = w_prod[15:8];
      2'd3: w_wdata = w_prod[7:0];
    endcase
  end

  // Gated by start so an aborting cycle never lands a byte.
  assign w_we = (r_state == STORE) && !start;

  data_mem dm (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_bc    <= '0;
      r_a_hi  <= '0;
      r_a_lo  <= '0;
      r_b_hi  <= '0;
      r_b_lo  <= '0;
      done    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          done <= 1'b0;
          r_k  <= '0;
          r_bc <= '0;
          if (!start) r_state <= LOAD;
        end
        LOAD: begin
          if (start) begin
            r_state <= IDLE;
            done    <= 1'b0;
          end else begin
            unique case (r_bc)
              2'd0: r_a_hi <= w_rdata;
              2'd1: r_a_lo <= w_rdata;
              2'd2: r_b_hi <= w_rdata;
              2'd3: r_b_lo <= w_rdata;
            endcase
            r_bc <= r_bc + 2'd1;
            if (r_bc == 2'd3) r_state <= STORE;
          end
        end
        STORE: begin
          if (start) begin
            r_state <= IDLE;
            done    <= 1'b0;
          end else begin
            r_bc <= r_bc + 2'd1;
            if (r_bc == 2'd3) begin
              r_k <= r_k + 4'd1;
              if (r_k == 4'(NUM_PAIRS - 1)) r_state <= DONE;
              else                          r_state <= LOAD;
            end
          end
        end
        DONE: begin
          if (start) begin
            r_state <= IDLE;
            done    <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut.sv
// Directed bench for the program-3 multiply engine.
module tb_dut;
  import dut_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ops [32];
  logic [31:0] expv [16];

  dut u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 32; i++) begin
      u_dut.dm.core[2*i]   = ops[i][15:8];
      u_dut.dm.core[2*i+1] = ops[i][7:0];
    end
    for (int i = 64; i < 128; i++) u_dut.dm.core[i] = 8'h55;
    for (int i = 128; i < 256; i++) u_dut.dm.core[i] = 8'hC3;
  endtask

  task automatic model_exp();
    for (int k = 0; k < 16; k++) begin
      logic signed [31:0] a, b;
      a = 32'($signed(ops[2*k]));
      b = 32'($signed(ops[2*k+1]));
      expv[k] = b * a;
    end
  endtask

  task automatic check_mem(input string tag);
    logic [31:0] got;
    int bad;
    for (int k = 0; k < 16; k++) begin
      got = {u_dut.dm.core[64+4*k], u_dut.dm.core[65+4*k],
             u_dut.dm.core[66+4*k], u_dut.dm.core[67+4*k]};
      chk($sformatf("%s_prod%0d", tag, k), got, expv[k]);
    end
    bad = 0;
    for (int i = 0; i < 32; i++)
      if ({u_dut.dm.core[2*i], u_dut.dm.core[2*i+1]} !== ops[i]) bad++;
    chk({tag, "_operands_bad"}, 32'(bad), 32'd0);
    bad = 0;
    for (int i = 128; i < 256; i++)
      if (u_dut.dm.core[i] !== 8'hC3) bad++;
    chk({tag, "_upper_bad"}, 32'(bad), 32'd0);
  endtask

  // start high for one cycle then low; returns edges from first start=0 edge to done
  task automatic run(output int lat);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 32; i++) ops[i] = '0;
    #12;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_state", 32'(u_dut.r_state), 32'(IDLE));
    chk("reset_k", 32'(u_dut.r_k), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_start_high_done", 32'(done), 32'd0);

    // Directed pairs with hand-computed products
    ops[0]  = 16'h0003; ops[1]  = 16'hFFFE; expv[0] = 32'hFFFFFFFA;
    ops[2]  = 16'h8000; ops[3]  = 16'h8000; expv[1] = 32'h40000000;
    ops[4]  = 16'h7FFF; ops[5]  = 16'h8000; expv[2] = 32'hC0008000;
    ops[6]  = 16'h0000; ops[7]  = 16'h1234; expv[3] = 32'h00000000;
    ops[8]  = 16'h7FFF; ops[9]  = 16'h7FFF; expv[4] = 32'h3FFF0001;
    ops[10] = 16'hFFFF; ops[11] = 16'hFFFF; expv[5] = 32'h00000001;
    ops[12] = 16'h0100; ops[13] = 16'h0100; expv[6] = 32'h00010000;
    ops[14] = 16'hFF00; ops[15] = 16'h0002; expv[7] = 32'hFFFFFE00;
    for (int k = 8; k < 16; k++) expv[k] = 32'h0;
    load_mem();
    run(lat);
    chk("dir_latency", 32'(lat), 32'd129);
    check_mem("dir");
    repeat (5) @(posedge clk);
    #1 chk("done_held", 32'(done), 32'd1);
    start = 1'b1;
    @(posedge clk); #1;
    chk("done_cleared", 32'(done), 32'd0);
    chk("state_idle_after_done", 32'(u_dut.r_state), 32'(IDLE));

    // Repeated runs with fresh random memory
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 32; i++) ops[i] = 16'($urandom);
      model_exp();
      load_mem();
      run(lat);
      chk($sformatf("rand%0d_latency", f), 32'(lat), 32'd129);
      check_mem($sformatf("rand%0d", f));
      #1 start = 1'b1;
      @(posedge clk); #1;
    end

    // Reset mid-run
    for (int i = 0; i < 32; i++) ops[i] = 16'($urandom);
    model_exp();
    load_mem();
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #2 reset = 1'b1; start = 1'b1;
    #1;
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_state", 32'(u_dut.r_state), 32'(IDLE));
    seen = 0;
    for (int i = 0; i < 32; i++)
      if ({u_dut.dm.core[2*i], u_dut.dm.core[2*i+1]} !== ops[i]) seen++;
    chk("rst_mid_operands_bad", 32'(seen), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    run(lat);
    chk("rst_rerun_latency", 32'(lat), 32'd129);
    check_mem("rst_rerun");
    #1 start = 1'b1;

    // Abort by raising start mid-run
    for (int i = 0; i < 32; i++) ops[i] = 16'($urandom);
    model_exp();
    load_mem();
    @(posedge clk); #1 start = 1'b0;
    repeat (60) @(posedge clk);
    #1 start = 1'b1;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("abort_done_seen", 32'(seen), 32'd0);
    chk("abort_state", 32'(u_dut.r_state), 32'(IDLE));
    run(lat);
    chk("abort_rerun_latency", 32'(lat), 32'd129);
    check_mem("abort_rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dut.md
# dut

Program-3 engine: double-precision (16×16 → 32-bit) two's-complement multiplier that runs autonomously over its own byte-wide data memory. On a start request it computes 16 signed products from 32 operands stored in memory bytes 0–63. It writes the results big-endian to bytes 64–127, then raises done. It is the top-level processor block; the bench preloads and inspects memory hierarchically through instance `dm`.

## Interface
- NUM_PAIRS, 16, number of operand pairs and products
- OPERAND_BASE, 0, byte address of first operand
- RESULT_BASE, 64, byte address of first product
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  level request; high = hold idle, low = run
- done  output  1  high when all products are written; held until start returns high

## Operation
- Operand i (i = 0..31) is the signed 16-bit value {core[OPERAND_BASE+2i], core[OPERAND_BASE+2i+1]}; the first byte is the MSB.
- Product k (k = 0..15) = operand[2k+1] × operand[2k], a full signed 32-bit result with no truncation or saturation.
- Product k is stored at core[RESULT_BASE+4k .. +4k+3], MSB first.
- Bytes outside 64–127 are never written. Operands are never modified.
- FSM states:
  - IDLE: done = 0. Leave to LOAD when start = 0.
  - LOAD: 4 cycles. Read operand bytes 4k..4k+3 into the A (hi, lo) and B (hi, lo) registers.
  - STORE: 4 cycles. Write product bytes MSB → LSB; k increments after the last byte. If k = 15, go to DONE; otherwise go to LOAD.
  - DONE: done = 1. Return to IDLE when start = 1.
- start rising at any time forces IDLE and clears done; the run aborts and partial results may remain.
- A new run begins on each high→low sequence of start. Each run restarts at k = 0 and recomputes from current memory contents.
- reset forces IDLE, done = 0, and k = 0. reset never clears memory contents.

## Timing
- Reset values: done = 0, state = IDLE, all datapath registers = 0.
- Memory read is combinational on the address; memory write is synchronous on the rising clk.
- Per pair: 4 LOAD cycles + 4 STORE cycles = 8 cycles. The multiply is combinational between LOAD and STORE.
- Latency from the first clk edge with start = 0 to done = 1 is 129 cycles: 128 cycles of work plus one cycle to enter DONE.
- done is registered, changes only on clk edges, and is never asserted while start = 1.
- Product k is fully in memory before LOAD of pair k+1 begins. All 64 result bytes are valid by the cycle done rises.
- Asynchronous reset mid-run: the FSM goes to IDLE immediately. Any in-flight byte write is dropped.

## Structure
- Shared package `dut_pkg`: NUM_PAIRS, OPERAND_BASE, RESULT_BASE, MEM_DEPTH = 256, the byte_t typedef (8-bit), and the state enum {IDLE, LOAD, STORE, DONE}.
- One sub-module, `data_mem`, instantiated as `dm`:
  - 256 × 8-bit array named `core`
  - one combinational read port and one synchronous write port
  - no reset on the array
- Top holds the FSM, the 4-bit pair counter, the 2-bit byte counter, the operand registers, and the signed multiplier.

## Test plan
- Basic pair: preload bytes 0–3 = 00 03 FF FE (op0 = 3, op1 = −2); start 1→0 → after done, bytes 64–67 = FF FF FF FA (−6).
- Extremes:
  - op0 = op1 = 0x8000 → product 0x40000000
  - op0 = 0x7FFF, op1 = 0x8000 → product 0xC0008000
  - op0 = 0, op1 = 0x1234 → product 0x00000000
- Full sweep: load 32 random signed values → all 16 products match operand[2k+1] × operand[2k]; done rises exactly 129 cycles after start falls; bytes 0–63 unchanged.
- Handshake: done stays 0 while start = 1; done stays 1 after completion until start goes high; then start low reruns with newly loaded memory and produces the correct new products (repeat for 10 files).
- Reset mid-run: assert reset at cycle 40 → done = 0 and state IDLE immediately; memory preserved. Release reset, toggle start → all products correct.
- Abort: raise start at cycle 60 → done never asserts; FSM in IDLE; a subsequent run completes correctly.
